fpu_result_uart_tx: RTL and testbench
=====================================

Name: fpu_result_uart_tx

Overview:
- UART 8N1 transmitter that serialises a 16-bit Bfloat16 FPU result back to the host.
- Return-path counterpart of the UART receiver that feeds the FPU FSM top: receiver brings operands in, this block sends results out.
- Sits beside the FPU FSM top inside the user project. Driven by the FPU result plus a valid strobe; tx_serial_o goes to an output pad and an LA bit.

Parameters:
- DATA_W, 16, result width in bits; must be a multiple of 8; sent as DATA_W/8 bytes.
- CPB_W, 16, width of the runtime CLKS_PER_BIT input.

Ports:
- clk  input  1  single system clock.
- rst_l  input  1  synchronous active-low reset.
- CLKS_PER_BIT  input  CPB_W  clocks per UART bit; latched at frame acceptance.
- tx_data_i  input  DATA_W  result word to send.
- tx_valid_i  input  1  tx_data_i is valid.
- tx_ready_o  output  1  block can accept a word; high only in IDLE.
- tx_serial_o  output  1  UART line, registered, idle high.
- tx_active_o  output  1  high from START of the first byte through STOP of the last byte.
- tx_done_o  output  1  one-cycle pulse after the final stop bit completes.

Behaviour:
- Reset (rst_l=0 sampled at a clk edge): state IDLE, tx_serial_o=1, tx_ready_o=1 once out of reset (0 while rst_l=0), tx_active_o=0, tx_done_o=0, counters 0.
- Reset mid-frame aborts immediately. The line returns to 1 on that edge; no partial byte completes.
- Handshake: transfer occurs when tx_valid_i && tx_ready_o at a rising edge. tx_data_i and CLKS_PER_BIT are latched on that edge.
- CLKS_PER_BIT changes after acceptance have no effect until the next frame.
- Latched CPB value 0 is treated as 1.
- FSM states: IDLE -> START -> DATA -> STOP -> (START for next byte | DONE) -> IDLE.
- START: tx_serial_o=0 for CPB cycles, beginning the cycle after acceptance (latency 1 clk).
- DATA: 8 bits, LSB first, each held CPB cycles. A 3-bit bit index wraps 7->0 on exit.
- STOP: tx_serial_o=1 for CPB cycles.
- Byte order: most-significant byte first (sign/exponent byte, then mantissa byte). Byte counter runs 0..DATA_W/8-1.
- Consecutive bytes within one word have no idle gap: STOP goes directly to the next START.
- DONE: one cycle; tx_done_o=1, tx_serial_o=1, tx_active_o=0, tx_ready_o=0. Then IDLE with tx_ready_o=1.
- Timing: acceptance edge to tx_done_o = 1 + (DATA_W/8)*10*CPB cycles. Next acceptance is possible 1 cycle after the DONE cycle.
- tx_valid_i while busy is ignored, not queued. The producer must hold valid until ready.
- Baud counter: counts 0..CPB-1, then resets and advances the bit. Width CPB_W, no overflow possible.

Optional Feature:
- Macro: FPU_UART_TX_PARITY_EN.
- Defined: a PARITY state sits between DATA and STOP and sends the even-parity bit (XOR of the 8 data bits) for CPB cycles. Each byte is 11 bits; total latency becomes 1 + (DATA_W/8)*11*CPB.
- Undefined: no PARITY state, plain 8N1 as above.

Decomposition:
- Shared package fpu_uart_pkg holds:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP, DONE), shared with the receiver;
  - UART_DATA_BITS=8;
  - default CLKS_PER_BIT=348.
- One natural sub-module, uart_baud_tick: loadable down-counter producing a bit-period tick from the latched CPB. The receiver reuses it.
- Byte/bit sequencing stays in the top FSM.

Test Plan:
- Basic send: CPB=4, send 0x3F80 (bf16 1.0). Line shows 0, bits of 0x3F LSB first (1,1,1,1,1,1,0,0), 1, then 0, bits of 0x80 (0,0,0,0,0,0,0,1), 1, each held 4 clks. tx_done_o pulses exactly 81 clks after acceptance.
- Back-to-back: send 0xC040 then 0x0001 with valid held high. The second word is accepted 1 clk after the first DONE cycle; the decoded bytes are C0,40,00,01.
- Busy ignore: pulse valid with 0xFFFF mid-frame. The current frame is unaffected and 0xFFFF is never transmitted.
- Reset mid-frame: rst_l=0 during DATA of byte 0. Next edge gives tx_serial_o=1, tx_active_o=0, ready=1 after release. A new 0x1234 then sends correctly.
- Degenerate rate: CPB=0 behaves identically to CPB=1. Changing CPB from 4 to 8 mid-frame leaves the current frame at 4 clks/bit.
- With FPU_UART_TX_PARITY_EN: CPB=2, send 0x0700. Parity bits are 1 then 0, and tx_done_o comes at 45 clks.

Source files
------------

// File: rtl/fpu_uart_pkg.sv
// ---------------------------------------------------------------------------
// fpu_uart_pkg
//
// Purpose : Definitions shared by the FPU UART receiver and the FPU result
//           transmitter: the framing state encoding, the number of data bits
//           per UART character, the default bit period and a parity helper.
//
// Contents:
//   UART_DATA_BITS        data bits per character (8)
//   DEFAULT_CLKS_PER_BIT  default clocks per bit (348)
//   uart_state_e          IDLE, START, DATA, PARITY, STOP, DONE
//   even_parity()         even parity bit of one character
// ---------------------------------------------------------------------------
package fpu_uart_pkg;

   localparam int UART_DATA_BITS       = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 348;

   // Encoding is fixed so the receiver and the transmitter agree on it
   // when the state is observed on the logic analyser.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      DONE   = 3'd5
   } uart_state_e;

   // Even parity: the parity bit makes the total count of ones even,
   // which is simply the XOR of the data bits.
   function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] char_bits);
      return ^char_bits;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
//
// Purpose : Loadable down-counter that marks the last clock of every UART bit
//           period. Loaded with the period on frame acceptance, then reloads
//           itself each time it ticks so consecutive bits follow without gaps.
//
// Ports:
//   clk       in   system clock
//   rst_l     in   synchronous active-low reset (counter cleared)
//   load_i    in   restart the count from period_i (no tick this cycle)
//   period_i  in   bit period in clocks, must be >= 1
//   en_i      in   count enable (high while a frame is on the line)
//   tick_o    out  high on the last clock of the current bit period
// ---------------------------------------------------------------------------
module uart_baud_tick #(
   parameter int CPB_W = 16
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             load_i,
   input  logic [CPB_W-1:0] period_i,
   input  logic             en_i,
   output logic             tick_o
);

   logic [CPB_W-1:0] count_reg;
   logic [CPB_W-1:0] count_next;

   // The count runs period-1 down to 0, so a bit lasts exactly period clocks.
   assign tick_o = en_i && !load_i && (count_reg == '0);

   always_comb begin
      count_next = count_reg;
      if (load_i || tick_o) begin
         count_next = period_i - CPB_W'(1);
      end else if (en_i) begin
         count_next = count_reg - CPB_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/fpu_result_uart_tx.sv
// ---------------------------------------------------------------------------
// fpu_result_uart_tx
//
// Purpose : UART transmitter that returns a Bfloat16 FPU result to the host.
//           The result word is sent as DATA_W/8 characters, most-significant
//           byte first, each character framed as start bit, 8 data bits LSB
//           first, stop bit. Characters of one word follow with no idle gap.
//
// Build option:
//   FPU_UART_TX_PARITY_EN  when defined, an even-parity bit is inserted
//                          between the data bits and the stop bit (8E1).
//
// Parameters:
//   DATA_W  result width, a multiple of 8
//   CPB_W   width of the runtime clocks-per-bit input
//
// Ports:
//   clk           in   system clock
//   rst_l         in   synchronous active-low reset, aborts any frame
//   CLKS_PER_BIT  in   clocks per bit, latched on acceptance (0 acts as 1)
//   tx_data_i     in   result word, latched on acceptance
//   tx_valid_i    in   tx_data_i valid; held by the producer until ready
//   tx_ready_o    out  high in IDLE only (and never during reset)
//   tx_serial_o   out  registered UART line, idle high
//   tx_active_o   out  high from the first start bit to the last stop bit
//   tx_done_o     out  one-clock pulse once the final stop bit has ended
// ---------------------------------------------------------------------------
module fpu_result_uart_tx
   import fpu_uart_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int CPB_W  = 16
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic [CPB_W-1:0]  CLKS_PER_BIT,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic              tx_serial_o,
   output logic              tx_active_o,
   output logic              tx_done_o
);

   localparam int N_BYTES    = DATA_W / UART_DATA_BITS;
   localparam int BYTE_IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(N_BYTES - 1);
   localparam logic [2:0]            LAST_BIT  = 3'(UART_DATA_BITS - 1);

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   uart_state_e             state_reg,    state_next;
   logic [DATA_W-1:0]       data_reg,     data_next;
   logic [CPB_W-1:0]        cpb_reg,      cpb_next;
   logic [2:0]              bit_idx_reg,  bit_idx_next;
   logic [BYTE_IDX_W-1:0]   byte_idx_reg, byte_idx_next;
   logic                    serial_reg,   serial_next;

   logic                    accept;
   logic                    line_busy;
   logic                    bit_tick;
   logic [CPB_W-1:0]        cpb_in_eff;
   logic [CPB_W-1:0]        baud_period;
   logic [UART_DATA_BITS-1:0] cur_byte;

   // ------------------------------------------------------------------
   // Byte lanes of the latched word, lane 0 = most-significant byte, so
   // the byte counter walks the word in transmission order.
   // ------------------------------------------------------------------
   logic [UART_DATA_BITS-1:0] byte_lane [N_BYTES];

   generate
      for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_lane
         assign byte_lane[gi] = data_reg[DATA_W-1-UART_DATA_BITS*gi -: UART_DATA_BITS];
      end
   endgenerate

   assign cur_byte = byte_lane[byte_idx_reg];

   // ------------------------------------------------------------------
   // Handshake and bit timing
   // ------------------------------------------------------------------
   assign tx_ready_o = rst_l && (state_reg == IDLE);
   assign accept     = tx_valid_i && tx_ready_o;

   // A zero rate would stall the counter forever; run it as one clock/bit.
   assign cpb_in_eff = (CLKS_PER_BIT == '0) ? CPB_W'(1) : CLKS_PER_BIT;

   // On the acceptance edge cpb_reg still holds the previous frame's rate,
   // so the counter is loaded straight from the input that is being latched.
   assign baud_period = accept ? cpb_in_eff : cpb_reg;

   always_comb begin
      line_busy = 1'b0;
      case (state_reg)
         START, DATA, PARITY, STOP: line_busy = 1'b1;
         default:                   line_busy = 1'b0;
      endcase
   end

   uart_baud_tick #(
      .CPB_W (CPB_W)
   ) u_baud_tick (
      .clk      (clk),
      .rst_l    (rst_l),
      .load_i   (accept),
      .period_i (baud_period),
      .en_i     (line_busy),
      .tick_o   (bit_tick)
   );

   // ------------------------------------------------------------------
   // Frame sequencer. serial_next is the line level for the state being
   // entered, so the registered line lines up with the state register.
   // ------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      data_next     = data_reg;
      cpb_next      = cpb_reg;
      bit_idx_next  = bit_idx_reg;
      byte_idx_next = byte_idx_reg;
      serial_next   = serial_reg;

      case (state_reg)
         IDLE: begin
            serial_next = 1'b1;
            if (accept) begin
               data_next     = tx_data_i;
               cpb_next      = cpb_in_eff;
               bit_idx_next  = '0;
               byte_idx_next = '0;
               state_next    = START;
               serial_next   = 1'b0;
            end
         end

         START: begin
            if (bit_tick) begin
               state_next  = DATA;
               serial_next = cur_byte[0];
            end
         end

         DATA: begin
            if (bit_tick) begin
               if (bit_idx_reg == LAST_BIT) begin
                  bit_idx_next = '0;
`ifdef FPU_UART_TX_PARITY_EN
                  state_next   = PARITY;
                  serial_next  = even_parity(cur_byte);
`else
                  state_next   = STOP;
                  serial_next  = 1'b1;
`endif
               end else begin
                  bit_idx_next = bit_idx_reg + 3'd1;
                  serial_next  = cur_byte[bit_idx_reg + 3'd1];
               end
            end
         end

`ifdef FPU_UART_TX_PARITY_EN
         PARITY: begin
            if (bit_tick) begin
               state_next  = STOP;
               serial_next = 1'b1;
            end
         end
`endif

         STOP: begin
            if (bit_tick) begin
               if (byte_idx_reg == LAST_BYTE) begin
                  byte_idx_next = '0;
                  state_next    = DONE;
                  serial_next   = 1'b1;
               end else begin
                  // Next character starts straight away: no idle gap
                  // between the bytes of one word.
                  byte_idx_next = byte_idx_reg + BYTE_IDX_W'(1);
                  state_next    = START;
                  serial_next   = 1'b0;
               end
            end
         end

         DONE: begin
            state_next  = IDLE;
            serial_next = 1'b1;
         end

         default: begin
            state_next  = IDLE;
            serial_next = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         state_reg    <= IDLE;
         data_reg     <= '0;
         cpb_reg      <= CPB_W'(1);
         bit_idx_reg  <= '0;
         byte_idx_reg <= '0;
         serial_reg   <= 1'b1;
      end else begin
         state_reg    <= state_next;
         data_reg     <= data_next;
         cpb_reg      <= cpb_next;
         bit_idx_reg  <= bit_idx_next;
         byte_idx_reg <= byte_idx_next;
         serial_reg   <= serial_next;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign tx_serial_o = serial_reg;
   assign tx_active_o = line_busy;
   assign tx_done_o   = (state_reg == DONE);

endmodule

// File: tb/tb_fpu_result_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fpu_result_uart_tx
//
// Self-checking bench for fpu_result_uart_tx. The expected line level for
// every clock of a frame is derived from the word, the effective bit period
// and the character format; the handshake, active and done outputs are
// checked alongside. Define FPU_UART_TX_PARITY_EN for the 8E1 build.
// ---------------------------------------------------------------------------
module tb_fpu_result_uart_tx;

   localparam int DATA_W  = 16;
   localparam int CPB_W   = 16;
   localparam int N_BYTES = DATA_W / 8;
`ifdef FPU_UART_TX_PARITY_EN
   localparam int BITS_PER_BYTE = 11;
`else
   localparam int BITS_PER_BYTE = 10;
`endif

   logic              clk;
   logic              rst_l;
   logic [CPB_W-1:0]  CLKS_PER_BIT;
   logic [DATA_W-1:0] tx_data_i;
   logic              tx_valid_i;
   logic              tx_ready_o;
   logic              tx_serial_o;
   logic              tx_active_o;
   logic              tx_done_o;

   int n_checks = 0;
   int n_fail   = 0;

   fpu_result_uart_tx #(
      .DATA_W (DATA_W),
      .CPB_W  (CPB_W)
   ) dut (
      .clk          (clk),
      .rst_l        (rst_l),
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .tx_data_i    (tx_data_i),
      .tx_valid_i   (tx_valid_i),
      .tx_ready_o   (tx_ready_o),
      .tx_serial_o  (tx_serial_o),
      .tx_active_o  (tx_active_o),
      .tx_done_o    (tx_done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Line level of bit slot 'slot' within the frame of word w.
   function automatic logic exp_line(input logic [15:0] w, input int slot);
      int         byte_no;
      int         pos;
      logic [7:0] b;
      byte_no = slot / BITS_PER_BYTE;
      pos     = slot % BITS_PER_BYTE;
      b       = 8'((w >> (8 * (N_BYTES - 1 - byte_no))) & 16'h00FF);
      if (pos == 0) return 1'b0;
      if (pos <= 8) return b[pos-1];
      if (BITS_PER_BYTE == 11 && pos == 9) return ^b;
      return 1'b1;
   endfunction

   // Offer one word, wait (bounded) for acceptance, then check every clock
   // of the frame and the done cycle. new_cpb >= 0 changes the rate input
   // mid-frame; busy_at > 0 pulses valid with 0xFFFF at that frame clock.
   task automatic send_frame(input logic [15:0] w, input int cpb, input int new_cpb,
                             input int busy_at, input bit hold_valid, input bit expect_immediate);
      int eff;
      int total;
      int waited;
      @(negedge clk);
      tx_data_i    = w;
      CLKS_PER_BIT = CPB_W'(cpb);
      tx_valid_i   = 1'b1;
      waited = 0;
      while (!tx_ready_o && waited < 5000) begin
         @(negedge clk);
         waited++;
      end
      if (!tx_ready_o) begin
         check("ready_timeout", 32'(tx_ready_o), 32'd1);
         tx_valid_i = 1'b0;
         return;
      end
      if (expect_immediate) check("b2b_accept_gap", 32'(waited), 32'd0);
      @(posedge clk);
      #1;
      if (!hold_valid) tx_valid_i = 1'b0;
      eff   = (cpb == 0) ? 1 : cpb;
      total = N_BYTES * BITS_PER_BYTE * eff;
      $display("tx word=%h cpb=%0d eff=%0d clocks_to_done=%0d", w, cpb, eff, total + 1);
      for (int k = 1; k <= total; k++) begin
         @(negedge clk);
         check($sformatf("line w=%h k=%0d", w, k), 32'(tx_serial_o), 32'(exp_line(w, (k - 1) / eff)));
         check("active_in_frame", 32'(tx_active_o), 32'd1);
         check("done_in_frame", 32'(tx_done_o), 32'd0);
         check("ready_in_frame", 32'(tx_ready_o), 32'd0);
         if (k == 3 && new_cpb >= 0) CLKS_PER_BIT = CPB_W'(new_cpb);
         if (busy_at > 0 && k == busy_at) begin
            tx_data_i  = 16'hFFFF;
            tx_valid_i = 1'b1;
         end
         if (busy_at > 0 && k == busy_at + 1) tx_valid_i = 1'b0;
      end
      @(negedge clk);
      check("done_pulse", 32'(tx_done_o), 32'd1);
      check("done_line", 32'(tx_serial_o), 32'd1);
      check("done_active", 32'(tx_active_o), 32'd0);
      check("done_ready", 32'(tx_ready_o), 32'd0);
   endtask

   // Line must stay idle: nothing accepted, done low.
   task automatic check_idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check("idle_line", 32'(tx_serial_o), 32'd1);
         check("idle_active", 32'(tx_active_o), 32'd0);
         check("idle_done", 32'(tx_done_o), 32'd0);
         check("idle_ready", 32'(tx_ready_o), 32'd1);
      end
   endtask

   initial begin
      logic [15:0] w;
      int          cpb;
      int          waited;

      rst_l        = 1'b0;
      tx_valid_i   = 1'b0;
      tx_data_i    = '0;
      CLKS_PER_BIT = CPB_W'(4);

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_line", 32'(tx_serial_o), 32'd1);
      check("rst_active", 32'(tx_active_o), 32'd0);
      check("rst_done", 32'(tx_done_o), 32'd0);
      check("rst_ready_low", 32'(tx_ready_o), 32'd0);
      rst_l = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(tx_ready_o), 32'd1);
      check("post_rst_line", 32'(tx_serial_o), 32'd1);

      // Basic send of bf16 1.0
      send_frame(16'h3F80, 4, -1, 0, 1'b0, 1'b0);
      check_idle(2);

`ifdef FPU_UART_TX_PARITY_EN
      send_frame(16'h0700, 2, -1, 0, 1'b0, 1'b0);
      check_idle(2);
`endif

      // Back-to-back with valid held high
      send_frame(16'hC040, 4, -1, 0, 1'b1, 1'b0);
      send_frame(16'h0001, 4, -1, 0, 1'b0, 1'b1);
      check_idle(2);

      // Valid pulsed while busy is ignored
      send_frame(16'h5A5A, 4, -1, 20, 1'b0, 1'b0);
      check_idle(10);

      // Reset during the data bits of byte 0
      @(negedge clk);
      tx_data_i    = 16'hA5C3;
      CLKS_PER_BIT = CPB_W'(4);
      tx_valid_i   = 1'b1;
      waited = 0;
      while (!tx_ready_o && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check("rst_test_ready", 32'(tx_ready_o), 32'd1);
      @(posedge clk);
      #1;
      tx_valid_i = 1'b0;
      repeat (9) @(negedge clk);
      check("pre_abort_active", 32'(tx_active_o), 32'd1);
      rst_l = 1'b0;
      $display("tx word=a5c3 aborted by reset");
      @(negedge clk);
      check("abort_line", 32'(tx_serial_o), 32'd1);
      check("abort_active", 32'(tx_active_o), 32'd0);
      check("abort_done", 32'(tx_done_o), 32'd0);
      check("abort_ready", 32'(tx_ready_o), 32'd0);
      rst_l = 1'b1;
      check_idle(3);
      send_frame(16'h1234, 4, -1, 0, 1'b0, 1'b0);

      // Degenerate rate: 0 behaves as 1
      send_frame(16'h9E37, 0, -1, 0, 1'b0, 1'b0);
      send_frame(16'h9E37, 1, -1, 0, 1'b0, 1'b0);

      // Rate change mid-frame has no effect on the current frame
      send_frame(16'h6B2D, 4, 8, 0, 1'b0, 1'b0);
      send_frame(16'h00FF, 8, -1, 0, 1'b0, 1'b0);
      check_idle(2);

      // Randomised words and rates
      for (int n = 0; n < 10; n++) begin
         w   = 16'($urandom);
         cpb = int'($urandom_range(0, 5));
         send_frame(w, cpb, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6)) : -1,
                    ($urandom_range(0, 1) == 1) ? 5 : 0, 1'b0, 1'b0);
      end
      check_idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
